bound_flasher_core: RTL and testbench

- Lamp-sequencing state machine for the BoundFlasher design; sits directly downstream of system_clock_generator.
- Its clk is the generator's clk_div, so the prescaler selection sets the lamp step rate.
- Drives a thermometer-coded lamp bar through a fixed on/off "bound" pattern once per flick request.
- Supports kickback (reversal) when flick is asserted at defined bound points.

---
 rtl/bound_flasher_core.sv | 134 +++++++++++++
 tb/tb_bound_flasher_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_core.sv
// Bound flasher lamp sequencer. Steps a thermometer-coded lamp bar up and down
// between fixed bound points once per flick request. Flick at the low or high
// bound point while rising in S1/S3 reverses the bar (kickback). All outputs are
// registered, so there is no combinational path from flick to the lamps.
module bound_flasher_core #(
    parameter int LAMP_W = 16,
    parameter int P_LO   = 5,
    parameter int P_HI   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flick,
    output logic [LAMP_W-1:0] lamp,
    output logic              busy,
    output logic [3:0]        state
);

    localparam int CW = $clog2(LAMP_W + 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S1   = 4'd1,
        S2   = 4'd2,
        S3   = 4'd3,
        S4   = 4'd4,
        S5   = 4'd5,
        S6   = 4'd6,
        KB1  = 4'd7,
        KB3  = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [LAMP_W-1:0] r_lamp;
    logic              r_busy;
    logic              w_kick;

    // Rising states count up, everything else counts down.
    function automatic logic is_up(input state_t s);
        return (s == S1) || (s == S3) || (s == S5);
    endfunction

    // Count value at which each state hands over to its successor.
    function automatic logic [CW-1:0] target_of(input state_t s);
        case (s)
            S1:       return CW'(LAMP_W);
            S2, KB3:  return CW'(P_LO);
            S3:       return CW'(P_HI + 1);
            S5:       return CW'(P_LO + 1);
            default:  return '0;
        endcase
    endfunction

    // Successor once the target has been displayed for one cycle.
    function automatic state_t next_of(input state_t s);
        case (s)
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S5;
            S5:      return S6;
            KB1:     return S1;
            KB3:     return S3;
            default: return IDLE;
        endcase
    endfunction

    // Thermometer decode: the c lowest lamps lit.
    function automatic logic [LAMP_W-1:0] thermo(input logic [CW-1:0] c);
        logic [LAMP_W-1:0] t;
        for (int i = 0; i < LAMP_W; i++) begin
            t[i] = (CW'(i) < c);
        end
        return t;
    endfunction

    // Kickback only applies while rising in S1/S3 at one of the two bound points.
    assign w_kick = flick && ((r_state == S1) || (r_state == S3)) &&
                    ((r_cnt == CW'(P_LO + 1)) || (r_cnt == CW'(P_HI + 1)));

    // Next state and count; priority is start, kickback, target reached, step.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (flick) begin
                    w_state_nxt = S1;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S1, S2, S3, S4, S5, S6, KB1, KB3: begin
                if (w_kick) begin
                    w_state_nxt = (r_state == S1) ? KB1 : KB3;
                    w_cnt_nxt   = r_cnt - CW'(1);
                end else if (r_cnt == target_of(r_state)) begin
                    w_state_nxt = next_of(r_state);
                    if (next_of(r_state) != IDLE) begin
                        w_cnt_nxt = is_up(next_of(r_state)) ? r_cnt + CW'(1) : r_cnt - CW'(1);
                    end
                end else begin
                    w_state_nxt = r_state;
                    w_cnt_nxt   = is_up(r_state) ? r_cnt + CW'(1) : r_cnt - CW'(1);
                end
            end
            // Illegal encodings fall back to IDLE with the bar dark.
            default: ;
        endcase
    end

    // State, count and decoded outputs registered together under synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lamp  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lamp  <= thermo(w_cnt_nxt);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign lamp  = r_lamp;
    assign busy  = r_busy;
    assign state = r_state;

endmodule

// File: tb/tb_bound_flasher_core.sv
// Scoreboard bench for bound_flasher_core. The reference model keeps a queue of
// planned (state, lamp count) steps built from the segment table of the bound
// pattern; kickback and reset rewrite the plan. Stimulus pushes the expected
// output for each edge, and a separate monitor pops and compares it.
module tb_bound_flasher_core;

    localparam int LAMP_W = 16;
    localparam int P_LO   = 5;
    localparam int P_HI   = 10;

    logic              clk;
    logic              rst_n;
    logic              flick;
    logic [LAMP_W-1:0] lamp;
    logic              busy;
    logic [3:0]        state;

    bound_flasher_core #(.LAMP_W(LAMP_W), .P_LO(P_LO), .P_HI(P_HI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flick (flick),
        .lamp  (lamp),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
    } step_t;

    typedef struct {
        logic [3:0]        st;
        logic [LAMP_W-1:0] lamp;
        logic              busy;
    } exp_t;

    step_t plan[$];
    exp_t  exp_q[$];
    int    cur_st  = 0;
    int    cur_cnt = 0;
    int    n_chk   = 0;
    int    n_err   = 0;
    int    edge_no = 0;
    bit    track_max = 1'b0;
    logic [LAMP_W-1:0] max_seen = '0;

    // Nominal pattern as six ramps: state, first count, last count.
    int seg_st[6] = '{1, 2, 3, 4, 5, 6};
    int seg_a[6]  = '{1, LAMP_W - 1, P_LO + 1, P_HI, 1, P_LO};
    int seg_b[6]  = '{LAMP_W, P_LO, P_HI + 1, 0, P_LO + 1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic add_ramp(input int st, input int a, input int b);
        step_t s;
        s.st = st;
        if (a <= b) begin
            for (int i = a; i <= b; i++) begin s.cnt = i; plan.push_back(s); end
        end else begin
            for (int i = a; i >= b; i--) begin s.cnt = i; plan.push_back(s); end
        end
    endtask

    task automatic add_from(input int seg);
        step_t s;
        for (int k = seg; k < 6; k++) add_ramp(seg_st[k], seg_a[k], seg_b[k]);
        s.st = 0;
        s.cnt = 0;
        plan.push_back(s);
    endtask

    task automatic take_next();
        step_t s;
        s = plan.pop_front();
        cur_st  = s.st;
        cur_cnt = s.cnt;
    endtask

    // Advance the reference model by one clock edge.
    task automatic model_step(input logic r, input logic f);
        if (!r) begin
            plan.delete();
            cur_st  = 0;
            cur_cnt = 0;
        end else if (cur_st == 0) begin
            if (f) begin
                plan.delete();
                add_from(0);
                take_next();
            end
        end else if (f && (cur_st == 1 || cur_st == 3) &&
                     (cur_cnt == P_LO + 1 || cur_cnt == P_HI + 1)) begin
            plan.delete();
            if (cur_st == 1) begin
                add_ramp(7, cur_cnt - 1, 0);
                add_from(0);
            end else begin
                add_ramp(8, cur_cnt - 1, P_LO);
                add_from(2);
            end
            take_next();
        end else begin
            take_next();
        end
    endtask

    task automatic cycle(input logic r, input logic f);
        exp_t e;
        logic [31:0] full;
        @(negedge clk);
        #1;
        rst_n = r;
        flick = f;
        model_step(r, f);
        full   = (32'd1 << cur_cnt) - 32'd1;
        e.st   = 4'(cur_st);
        e.lamp = full[LAMP_W-1:0];
        e.busy = (cur_st != 0);
        exp_q.push_back(e);
    endtask

    // Idle-run until the model shows the given state/count, bounded.
    task automatic wait_for(input int st, input int cnt);
        int n = 0;
        while (!(cur_st == st && cur_cnt == cnt) && n < 300) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        check($sformatf("reach_s%0d_c%0d", st, cnt), 32'(n < 300), 32'd1);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                edge_no++;
                check($sformatf("state@%0d", edge_no), 32'(state), 32'(e.st));
                check($sformatf("lamp@%0d", edge_no), 32'(lamp), 32'(e.lamp));
                check($sformatf("busy@%0d", edge_no), 32'(busy), 32'(e.busy));
                if (track_max && lamp > max_seen) max_seen = lamp;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        flick = 1'b0;

        // Reset, then a single-cycle flick and the full nominal pattern.
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0);

        // Kickback in S1 at the low bound, then at the high bound, then in S3.
        cycle(1'b1, 1'b1);
        wait_for(1, P_LO + 1);
        cycle(1'b1, 1'b1);
        wait_for(1, P_HI + 1);
        cycle(1'b1, 1'b1);
        wait_for(3, P_HI + 1);
        cycle(1'b1, 1'b1);
        wait_for(0, 0);

        // Flick held through the states that ignore it.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 60; i++)
            cycle(1'b1, (cur_st == 2 || cur_st == 4 || cur_st == 5 || cur_st == 6));
        wait_for(0, 0);

        // Flick held from IDLE: S1/KB1 loop never lights beyond the low bound.
        track_max = 1'b1;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        track_max = 1'b0;
        check("hold_max_le_low_bound", 32'(max_seen <= LAMP_W'((1 << (P_LO + 1)) - 1)), 32'd1);
        check("hold_max_reached", 32'(max_seen), 32'((1 << (P_LO + 1)) - 1));
        wait_for(0, 0);

        // Reset during S4 with flick high aborts and does not start.
        cycle(1'b1, 1'b1);
        wait_for(4, 8);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

        // Randomised traffic with varying flick density and rare resets.
        for (int blk = 0; blk < 12; blk++) begin
            int dens = $urandom_range(0, 7);
            for (int i = 0; i < 200; i++) begin
                cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 7) < dens));
            end
        end
        cycle(1'b1, 1'b0);

        // Let the monitor drain the scoreboard.
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
